// File: rtl/opfetch_pkg.sv
// Shared types and constants for the operand fetch stage.
// Optional feature: define OPFETCH_SCOREBOARD_EN to build the busy-bit scoreboard.
package opfetch_pkg;

  // Issue slot occupancy: EMPTY means no op is being presented to execute.
  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } of_state_e;

  // The scoreboard keeps one busy bit per register, so its address width is
  // bounded to keep the vector a sane size.
  localparam int unsigned OF_MAX_SB_ADDR_WIDTH = 12;
  localparam int unsigned OF_MIN_WIDTH         = 1;

endpackage

// File: rtl/opfetch_scoreboard.sv
// Busy-bit scoreboard: one bit per register marking an outstanding write.
// A writeback in the current cycle hides the bit it clears, since the
// register file forwards written data into the same-edge read.
module opfetch_scoreboard
  import opfetch_pkg::*;
#(
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  set_i,
  input  logic [ADDR_WIDTH-1:0] set_addr_i,
  input  logic                  clr_i,
  input  logic [ADDR_WIDTH-1:0] clr_addr_i,
  input  logic [ADDR_WIDTH-1:0] r1_addr_i,
  input  logic [ADDR_WIDTH-1:0] r2_addr_i,
  input  logic [ADDR_WIDTH-1:0] dst_addr_i,
  input  logic                  dst_we_i,
  output logic                  hazard_o
);

  localparam int NREG = 1 << ADDR_WIDTH;

  logic [NREG-1:0] busy_q, busy_d;
  logic [NREG-1:0] clr_mask;
  logic [NREG-1:0] busy_eff;

  // Apply this cycle's clear first, then the set, so a set to the same
  // register in the same cycle wins.
  always_comb begin
    clr_mask = '0;
    if (clr_i) clr_mask[clr_addr_i] = 1'b1;
    busy_eff = busy_q & ~clr_mask;
    busy_d   = busy_eff;
    if (set_i) busy_d[set_addr_i] = 1'b1;
  end

  // Hazard lookup uses the post-clear view of the busy bits.
  always_comb begin
    hazard_o = busy_eff[r1_addr_i] | busy_eff[r2_addr_i] |
               (dst_we_i & busy_eff[dst_addr_i]);
  end

  // Busy vector register.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) busy_q <= '0;
    else          busy_q <= busy_d;
  end

endmodule

// File: rtl/operand_fetch.sv
// Operand fetch / issue stage. Accepts decoded ops, drives the register file
// read addresses and presents the (1-cycle latency) read data to execute.
// Optional feature: define OPFETCH_SCOREBOARD_EN to stall RAW/WAW hazards
// against writes that have not yet retired on the writeback port.
module operand_fetch
  import opfetch_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_r1_addr,
  input  logic [ADDR_WIDTH-1:0] req_r2_addr,
  input  logic [ADDR_WIDTH-1:0] req_dst_addr,
  input  logic                  req_dst_we,
  output logic [ADDR_WIDTH-1:0] rf_r1_addr,
  output logic [ADDR_WIDTH-1:0] rf_r2_addr,
  input  logic [DATA_WIDTH-1:0] rf_r1_data,
  input  logic [DATA_WIDTH-1:0] rf_r2_data,
  input  logic                  wb_valid,
  input  logic [ADDR_WIDTH-1:0] wb_addr,
  output logic                  op_valid,
  input  logic                  op_ready,
  output logic [DATA_WIDTH-1:0] op_a,
  output logic [DATA_WIDTH-1:0] op_b,
  output logic [ADDR_WIDTH-1:0] op_dst,
  output logic                  op_dst_we,
  output logic [CNT_WIDTH-1:0]  stall_cnt
);

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

  of_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0] s1_r1_q, s1_r2_q, s1_dst_q;
  logic                  s1_we_q;
  logic [CNT_WIDTH-1:0]  stall_cnt_q, stall_cnt_d;
  logic                  hazard;
  logic                  accept;
  logic                  consume;

`ifdef OPFETCH_SCOREBOARD_EN
  opfetch_scoreboard #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_sb (
    .clock      (clock),
    .reset_n    (reset_n),
    .set_i      (accept & req_dst_we),
    .set_addr_i (req_dst_addr),
    .clr_i      (wb_valid),
    .clr_addr_i (wb_addr),
    .r1_addr_i  (req_r1_addr),
    .r2_addr_i  (req_r2_addr),
    .dst_addr_i (req_dst_addr),
    .dst_we_i   (req_dst_we),
    .hazard_o   (hazard)
  );
`else
  // Without the scoreboard, ordering is the compiler's job; writeback is
  // only consumed by the register file itself.
  logic unused_wb;
  assign unused_wb = ^{wb_valid, wb_addr};
  assign hazard    = 1'b0;
`endif

  assign req_ready = ((state_q == EMPTY) | op_ready) & ~hazard;
  assign accept    = req_valid & req_ready;
  assign consume   = (state_q == FULL) & op_ready;

  // On accept the new op's sources go straight to the register file; while
  // held, the latched sources are re-read so stalled operands see writebacks.
  assign rf_r1_addr = accept ? req_r1_addr : s1_r1_q;
  assign rf_r2_addr = accept ? req_r2_addr : s1_r2_q;

  assign op_valid  = (state_q == FULL);
  assign op_a      = rf_r1_data;
  assign op_b      = rf_r2_data;
  assign op_dst    = s1_dst_q;
  assign op_dst_we = s1_we_q;
  assign stall_cnt = stall_cnt_q;

  // Slot occupancy: fill on accept, drain on consume without a new accept.
  always_comb begin
    state_d = state_q;
    case (state_q)
      EMPTY:   if (accept) state_d = FULL;
      FULL:    if (consume && !accept) state_d = EMPTY;
      default: state_d = EMPTY;
    endcase
  end

  // Saturating count of cycles where an op waits at the input.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (req_valid && !req_ready && (stall_cnt_q != {CNT_WIDTH{1'b1}}))
      stall_cnt_d = stall_cnt_q + CNT_ONE;
  end

  // State and stall counter registers.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= EMPTY;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  // Latch the accepted op's addresses and destination.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_r1_q  <= '0;
      s1_r2_q  <= '0;
      s1_dst_q <= '0;
      s1_we_q  <= 1'b0;
    end else if (accept) begin
      s1_r1_q  <= req_r1_addr;
      s1_r2_q  <= req_r2_addr;
      s1_dst_q <= req_dst_addr;
      s1_we_q  <= req_dst_we;
    end
  end

endmodule
